// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// wait-counter width and the byte-enable helper.
package dmem_responder_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte enables for an access: all four lanes for a word, one lane for a byte.
  function automatic logic [3:0] lane_be(input logic word, input logic [1:0] lane);
    lane_be = word ? 4'hF : (4'b0001 << lane);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_word;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_word, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_word, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder_array.sv
// DEPTH x 32 storage, byte-enable synchronous write, registered read.
// Contents are deliberately not reset.
module dmem_responder_array #(
  parameter  int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Lane-masked write and registered read of the addressed word.
  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// one-cycle response pulse, busy stall output.
// Optional feature macro: DMEM_ERR_EN (alignment and range error checks).
//
// state | meaning
// IDLE  | ready for a request; accept when req_valid
// WAIT  | counting wait states down to zero
// RESP  | resp_valid pulse; array was accessed on entry
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic              clock,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, word_q, err_q;
  logic [31:0]      addr_q, wdata_q;

  logic             accept, enter_resp, resp_on;
  logic             op_write, op_word, op_err;
  logic [31:0]      op_addr, op_wdata;
  logic [31:0]      arr_rdata, lane_data;

  assign accept     = rst && (state_q == ST_IDLE) && bus.req_valid;
  assign enter_resp = rst && (state_d == ST_RESP);

  // With zero wait states the array is accessed on the accept edge, before the
  // capture registers hold the request, so the live inputs are used then.
  assign op_write = (state_q == ST_IDLE) ? bus.req_write : write_q;
  assign op_word  = (state_q == ST_IDLE) ? bus.req_word  : word_q;
  assign op_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
  assign op_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;

`ifdef DMEM_ERR_EN
  assign op_err = (op_word && (op_addr[1:0] != 2'b00)) || (op_addr[31:IDX_W+2] != '0);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^op_addr[31:IDX_W+2];
  assign op_err = 1'b0;
`endif

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, request capture and registered error flag.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= bus.req_write;
        word_q  <= bus.req_word;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (enter_resp) err_q <= op_err;
    end
  end

  dmem_responder_array #(.DEPTH(DEPTH)) u_array (
    .clock   (clock),
    .we_i    (enter_resp && op_write && !op_err),
    .re_i    (enter_resp && !op_write && !op_err),
    .be_i    (lane_be(op_word, op_addr[1:0])),
    .idx_i   (op_addr[IDX_W+1:2]),
    .wdata_i (op_word ? op_wdata : {4{op_wdata[7:0]}}),
    .rdata_o (arr_rdata)
  );

  assign lane_data = word_q ? arr_rdata : {24'h0, arr_rdata[8*addr_q[1:0] +: 8]};
  assign resp_on   = rst && (state_q == ST_RESP);

  assign bus.req_ready  = rst && (state_q == ST_IDLE);
  assign bus.busy       = rst && ((state_q != ST_IDLE) || bus.req_valid);
  assign bus.resp_valid = resp_on;
  assign bus.resp_err   = resp_on && err_q;
  assign bus.resp_rdata = (resp_on && !err_q && !write_q) ? lane_data : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: driver pushes model-computed expectations, monitor pops
// and compares on every resp_valid. A second instance runs with zero waits.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int W     = 2;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  bit   mon_en = 0;
  bit   quiet = 0;
  exp_t q[$];
  logic [31:0] mem_m [DEPTH];

  dmem_responder_if bus();
  dmem_responder_if bus0();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clock (clk),
    .rst   (rst_n),
    .bus   (bus)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clock (clk),
    .rst   (rst_n),
    .bus   (bus0)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural memory: computes the response and updates storage.
  function automatic void model(input bit wr, input bit wd, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] rd, output logic er);
    int idx  = int'((a >> 2) % DEPTH);
    int lane = int'(a % 4);
    er = 1'b0;
    rd = '0;
`ifdef DMEM_ERR_EN
    if ((wd && lane != 0) || (a >= 32'(DEPTH * 4))) er = 1'b1;
`endif
    if (er) return;
    if (wr) begin
      if (wd) mem_m[idx] = d;
      else    mem_m[idx][lane*8 +: 8] = d[7:0];
    end else begin
      rd = wd ? mem_m[idx] : ((mem_m[idx] >> (lane * 8)) & 32'hFF);
    end
  endfunction

  function automatic void push(input bit wr, input bit wd, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    model(wr, wd, a, d, e.rd, e.er);
    e.acc = cyc;
    q.push_back(e);
  endfunction

  // Wait for ready, present the request for one accept edge, push its expectation.
  task automatic issue(input bit wr, input bit wd, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk); #1;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      nchk++; nfail++;
      $display("FAIL ready_timeout: got req_ready=%b expected 1", bus.req_ready);
      return;
    end
    bus.req_valid = 1; bus.req_write = wr; bus.req_word = wd;
    bus.req_addr = a; bus.req_wdata = d;
    push(wr, wd, a, d);
    @(posedge clk); #1;
    bus.req_valid = 0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      nchk++; nfail++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: busy tracking and response checking against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (!quiet) chk("busy", 32'(bus.busy), 32'(q.size() > 0));
      if (bus.resp_valid === 1'b1) begin
        if (q.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rdata",   bus.resp_rdata, e.rd);
          chk("err",     32'(bus.resp_err), 32'(e.er));
          chk("latency", 32'(cyc - e.acc), 32'(W + 1));
        end
      end
    end
  end

  initial begin
    logic [31:0] old20;
    rst_n = 0;
    bus.req_valid = 1; bus.req_write = 0; bus.req_word = 1;
    bus.req_addr = 0; bus.req_wdata = 0;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_word = 1;
    bus0.req_addr = 0; bus0.req_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_err",   32'(bus.resp_err), 32'd0);
    bus.req_valid = 0;
    @(negedge clk); #1;
    rst_n = 1;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    mon_en = 1;

    // Fill every word so the model has defined contents.
    for (int i = 0; i < DEPTH; i++) issue(1, 1, 32'(i * 4), $urandom);

    issue(1, 1, 32'h10, 32'hDEADBEEF);
    issue(0, 1, 32'h10, 32'h0);
    issue(1, 1, 32'h10, 32'h0);
    issue(1, 0, 32'h11, 32'hFFFFFF5A);
    issue(0, 1, 32'h10, 32'h0);
    issue(0, 0, 32'h11, 32'h0);
    drain();

    // Held request: accepted once every W+2 cycles.
    @(negedge clk); #1;
    bus.req_valid = 1; bus.req_write = 0; bus.req_word = 1; bus.req_addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      chk("hold_ready", 32'(bus.req_ready), 32'(i % 4 == 0));
      if (bus.req_ready === 1'b1) push(0, 1, 32'h10, 32'h0);
      if (i < 9) begin @(negedge clk); #1; end
    end
    @(posedge clk); #1;
    bus.req_valid = 0;
    drain();

`ifdef DMEM_ERR_EN
    issue(0, 1, 32'h13, 32'h0);
    issue(1, 1, 32'(DEPTH * 4), 32'h1234_5678);
    issue(0, 1, 32'h0, 32'h0);
`else
    issue(1, 1, 32'(DEPTH * 4), 32'h1);
    issue(0, 1, 32'h0, 32'h0);
`endif

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, DEPTH * 4 - 1));
      issue(1'($urandom), 1'($urandom), a, $urandom);
    end
    drain();

    // Reset during the last wait state of a store: the store must not commit.
    old20 = mem_m[8];
    @(negedge clk); #1;
    quiet = 1;
    bus.req_valid = 1; bus.req_write = 1; bus.req_word = 1;
    bus.req_addr = 32'h20; bus.req_wdata = ~old20;
    @(posedge clk); #1;
    bus.req_valid = 0;
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk); #1;
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    chk("midrst_busy",  32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1;
    #1;
    chk("midrst_release_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk); #1;
    quiet = 0;
    issue(0, 1, 32'h20, 32'h0);
    drain();

    // Zero-wait instance: store then loads held high, one accept every 2 cycles.
    @(negedge clk); #1;
    bus0.req_valid = 1; bus0.req_write = 1; bus0.req_word = 1;
    bus0.req_addr = 32'h8; bus0.req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      chk("w0_st_ready",  32'(bus0.req_ready), 32'(i % 2 == 0));
      chk("w0_st_rvalid", 32'(bus0.resp_valid), 32'(i % 2 == 1));
      @(negedge clk); #1;
    end
    bus0.req_write = 0;
    for (int i = 0; i < 6; i++) begin
      chk("w0_ld_ready",  32'(bus0.req_ready), 32'(i % 2 == 0));
      chk("w0_ld_rvalid", 32'(bus0.resp_valid), 32'(i % 2 == 1));
      if (i % 2 == 1) chk("w0_ld_rdata", bus0.resp_rdata, 32'hCAFEF00D);
      @(negedge clk); #1;
    end
    bus0.req_valid = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", nchk, nfail + 1);
    $fatal(1);
  end

endmodule
